// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = x - y - b_in, LSB first, one bit
// per clock through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Handshake: start is accepted only in IDLE (busy low), operands are captured on
    // that edge; done is a one-cycle pulse when d/b_out/ovf hold the new result.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             br_q, br_d;
    logic             xm_q, xm_d;
    logic             ym_q, ym_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;

    logic             bit_a, bit_c, diff, borrow_nxt;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_shift;

    assign bit_a      = xs_q[0];
    assign bit_c      = ys_q[0];
    assign diff       = bit_a ^ bit_c ^ br_q;
    assign borrow_nxt = (~bit_a & bit_c) | (~(bit_a ^ bit_c) & br_q);
    assign res_ext    = {diff, rs_q};
    assign res_shift  = res_ext[WIDTH:1];

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        rs_d    = rs_q;
        br_d    = br_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        b_out_d = b_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    br_d    = b_in;
                    xm_d    = x[WIDTH-1];
                    ym_d    = y[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                xs_d  = xs_q >> 1;
                ys_d  = ys_q >> 1;
                rs_d  = res_shift;
                br_d  = borrow_nxt;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the result only now, so d never shows partial sums.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = res_shift;
                    b_out_d = borrow_nxt;
                    ovf_d   = (xm_q ^ ym_q) & (xm_q ^ res_shift[WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            rs_q    <= '0;
            br_q    <= 1'b0;
            xm_q    <= 1'b0;
            ym_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            rs_q    <= rs_d;
            br_q    <= br_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign d         = d_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): arithmetic vectors, handshake
// robustness, asynchronous reset mid-operation and result hold.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         b_out;
    logic         ovf;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .b_out     (b_out),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: one full operation with result, latency and done-width checks.
    task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string tag);
        int lat;
        int busy_n;
        @(negedge clk);
        x = xv; y = yv; b_in = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = W'($urandom_range(0, 255));
        y = W'($urandom_range(0, 255));
        b_in = 1'($urandom_range(0, 1));
        busy_n = busy ? 1 : 0;
        lat = 99;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (busy) busy_n++;
            if (done) begin
                lat = e;
                break;
            end
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_busy_cycles"}, busy_n, 9);
        check({tag, "_d"}, d, ed);
        check({tag, "_b_out"}, b_out, eb);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
        check({tag, "_done_width"}, done, 0);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
        #1;
        check("rst_d", d, 0);
        check("rst_b_out", b_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Arithmetic vectors
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "sub_5_3");
        run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "sub_3_5");
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_0_0_bin");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "ovf_80_01");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "ovf_7f_ff");

        // start held high, operands churned after capture
        @(negedge clk);
        x = 8'h10; y = 8'h01; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int e = 1; e <= 18; e++) begin
            if (e == 10) begin
                x = 8'h33; y = 8'h11; b_in = 1'b0;
            end else begin
                x = W'($urandom_range(0, 255));
                y = W'($urandom_range(0, 255));
                b_in = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            if (e == 8) begin
                check("held_done1", done, 1);
                check("held_d1", d, 8'h0F);
            end
            if (e == 9) begin
                check("held_done1_width", done, 0);
                check("held_ignored_in_done", busy, 0);
            end
            if (e == 10) check("held_accept_edge10", busy, 1);
            if (e == 14) check("held_d_hold_during_shift", d, 8'h0F);
            if (e == 18) begin
                check("held_done2", done, 1);
                check("held_d2", d, 8'h22);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;

        // start pulses during SHIFT and DONE are ignored
        @(negedge clk);
        x = 8'h05; y = 8'h03; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_seen = 0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 2) begin
                start = 1'b1; x = 8'hFF; y = 8'h00;
            end
            if (e == 3) start = 1'b0;
            if (e == 8) start = 1'b1;
            if (e == 9) start = 1'b0;
            @(posedge clk); #1;
            if (done) done_seen++;
            if (e == 8) check("ign_d", d, 8'h02);
            if (e == 10) check("ign_idle_after_done", busy, 0);
        end
        check("ign_done_count", done_seen, 1);
        check("ign_d_hold", d, 8'h02);

        // Asynchronous reset during SHIFT cycle 4
        @(negedge clk);
        x = 8'h55; y = 8'h11; b_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_d", d, 0);
        check("arst_b_out", b_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_state", dbg_state, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        done_seen = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("arst_no_done", done_seen, 0);
        check("arst_d_stays_zero", d, 0);

        run_op(8'hA0, 8'h0A, 1'b0, 8'h96, 1'b0, 1'b0, "post_rst");
        repeat (6) @(posedge clk);
        #1;
        check("idle_hold_d", d, 8'h96);
        check("idle_hold_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes d = x - y - b_in, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic counterpart of the combinational full-adder chain.
- Sits beside the adder library as the area-minimal subtract path for multi-cycle datapaths.
- A start/done handshake controls it, and the result is held until the next operation.

Parameters:
WIDTH, 8, operand and result width in bits (legal: WIDTH >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
x  input  WIDTH  minuend; captured on accepted start
y  input  WIDTH  subtrahend; captured on accepted start
b_in  input  1  borrow-in; captured on accepted start
busy  output  1  high while in SHIFT or DONE
done  output  1  one-cycle pulse; result valid
d  output  WIDTH  difference, registered
b_out  output  1  final borrow (unsigned x < y + b_in)
ovf  output  1  signed overflow of x - y - b_in

Behaviour:
Clocking and reset:
- Single clock domain.
- Reset is asynchronous, active-low.
- While rst_n = 0, all state clears: state = IDLE, busy = 0, done = 0, d = 0, b_out = 0, ovf = 0, counter = 0, and the operand/shift registers and borrow FF = 0.
- Reset asserted mid-operation aborts immediately. No done is produced, and the aborted result never appears on d.

State machine (IDLE, SHIFT, DONE):
- IDLE: when start = 1 at an edge:
  - capture x into xs, y into ys, b_in into the borrow FF;
  - capture x[WIDTH-1] and y[WIDTH-1] for the overflow calculation;
  - clear the counter; next state = SHIFT.
- If start = 0 in IDLE, stay in IDLE.
- SHIFT, each edge:
  - a = xs[0], c = ys[0], br = borrow FF;
  - diff = a ^ c ^ br;
  - borrow_next = (~a & c) | (~(a ^ c) & br);
  - shift xs and ys right by 1;
  - shift the result register right by 1, inserting diff at bit WIDTH-1;
  - borrow FF <= borrow_next; counter += 1.
- Counter width is clog2(WIDTH + 1).
- On the edge that processes bit WIDTH-1 (counter == WIDTH-1):
  - load d <= final shifted result and b_out <= borrow_next;
  - load ovf <= (xm ^ ym) & (xm ^ result[WIDTH-1]);
  - next state = DONE.
- DONE: done = 1 for exactly this cycle; next state = IDLE unconditionally.

Handshake and outputs:
- busy = (state != IDLE), decoded from registered state.
- done = (state == DONE).
- start is ignored while busy, including in DONE. It is not queued.
- Inputs x, y, b_in may change freely after capture without affecting the result.

Latency and throughput:
- Start accepted at edge 0 → SHIFT for edges 1..WIDTH.
- d, b_out and ovf update at edge WIDTH. done is high from edge WIDTH to edge WIDTH+1.
- The earliest next accepted start is edge WIDTH+2. Throughput is one operation per WIDTH+2 cycles.

Output hold:
- d, b_out and ovf change only at the DONE-entry edge or on reset.
- They hold the last result indefinitely.

Boundary conditions:
- WIDTH = 1: one SHIFT cycle.
- Counter wrap never occurs; it is cleared on capture.
- All arithmetic is modulo 2^WIDTH. The borrow is exported, not saturated.

Test Plan:
- WIDTH=8; x=5, y=3, b_in=0, start pulse at edge 0 → done high after edge 8 for one cycle; d=0x02, b_out=0, ovf=0; busy high for 9 cycles.
- x=3, y=5, b_in=0 → d=0xFE, b_out=1, ovf=0.
- x=0x00, y=0x00, b_in=1 → d=0xFF, b_out=1.
- Signed overflow: x=0x80, y=0x01 → d=0x7F, b_out=0, ovf=1.
- Second signed overflow case: x=0x7F, y=0xFF → d=0x80, b_out=1, ovf=1.
- Handshake robustness:
  - start held high continuously, with x/y changed every cycle after capture (first op x=0x10, y=0x01) → results 0x0F, then the next op captured at edge 10;
  - start pulses during SHIFT and DONE are ignored;
  - done pulses are exactly 1 cycle wide.
- Reset mid-op:
  - drop rst_n asynchronously during SHIFT cycle 4 → outputs 0 immediately, state IDLE, no done;
  - after release, a fresh op x=0xA0, y=0x0A → d=0x96 at the correct latency;
  - a prior held result of d persists unchanged across unrelated idle cycles.
